// File: rtl/regfile_write_scheduler.sv
// Arbitrates the ARF write port between WB and buffered mul/div results, with a pending scoreboard (REGFILE_SCHED_BYPASS_EN: direct write of mc results into an idle port).
// Latency: WB writes 0 cycles, mc results >=1 cycle via FIFO (0 with bypass); backpressure via mc_ready=!full, sb_stall on hazards, pipe_stall on a starved head.

module regfile_write_scheduler_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + (AW+1)'(1);
      else if (!do_push && do_pop)
        count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module regfile_write_scheduler #(
  parameter int FIFO_DEPTH      = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_wr_en,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_wr_data,
  input  logic        dec_valid,
  input  logic        dec_is_mc,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  input  logic        mc_valid,
  output logic        mc_ready,
  input  logic [4:0]  mc_rd,
  input  logic [31:0] mc_data,
  output logic        wr_en,
  output logic [4:0]  wr_rd,
  output logic [31:0] wr_data,
  output logic        sb_stall,
  output logic        pipe_stall,
  output logic [31:0] pending
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } mc_res_t;

  mc_res_t       mc_in;
  mc_res_t       head;
  logic          fifo_empty;
  logic          fifo_full;
  logic          port_busy;
  logic          pop;
  logic          push;
  logic          bypass;
  logic          retire;
  logic [4:0]    retire_rd;
  logic [31:0]   retire_mask;
  logic [31:0]   issue_mask;
  logic [31:0]   hz_vec;
  logic [31:0]   pending_q;
  logic [31:0]   pending_next;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_next;
  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_next;
  logic          pipe_stall_q;
  logic          at_limit;
  logic          mc_issue;

  assign mc_in.rd   = mc_rd;
  assign mc_in.data = mc_data;

  // rd=0 writes are treated as no-ops, leaving the port free for the FIFO head.
  assign port_busy = rst_n && pipe_wr_en && (pipe_rd != 5'd0);
  assign pop       = !port_busy && !fifo_empty;
  assign mc_ready  = rst_n && !fifo_full;

`ifdef REGFILE_SCHED_BYPASS_EN
  assign bypass = !port_busy && fifo_empty && mc_valid && mc_ready;
`else
  assign bypass = 1'b0;
`endif

  assign push      = mc_valid && mc_ready && !bypass;
  assign retire    = pop || bypass;
  assign retire_rd = pop ? head.rd : mc_rd;

  regfile_write_scheduler_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(mc_res_t))
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (mc_in),
    .pop      (pop),
    .head_dat (head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_comb begin
    wr_en   = 1'b0;
    wr_rd   = 5'd0;
    wr_data = 32'd0;
    if (port_busy) begin
      wr_en   = 1'b1;
      wr_rd   = pipe_rd;
      wr_data = pipe_wr_data;
    end else if (pop) begin
      if (head.rd != 5'd0) begin
        wr_en   = 1'b1;
        wr_rd   = head.rd;
        wr_data = head.data;
      end
    end else if (bypass && (mc_rd != 5'd0)) begin
      wr_en   = 1'b1;
      wr_rd   = mc_rd;
      wr_data = mc_data;
    end
  end

  // A register retiring this cycle is not a hazard: the ARF bypasses the read.
  assign retire_mask = retire ? (32'd1 << retire_rd) : 32'd0;
  assign hz_vec      = pending_q & ~retire_mask;
  assign at_limit    = (cnt_q == CW'(MAX_OUTSTANDING));

  assign sb_stall = dec_valid && (hz_vec[dec_rs1] || hz_vec[dec_rs2] || hz_vec[dec_rd] ||
                                  (dec_is_mc && at_limit && !retire));
  assign mc_issue = dec_valid && dec_is_mc && !sb_stall && !pipe_stall_q;

  assign issue_mask   = (mc_issue && (dec_rd != 5'd0)) ? (32'd1 << dec_rd) : 32'd0;
  assign pending_next = ((pending_q & ~retire_mask) | issue_mask) & 32'hFFFF_FFFE;

  always_comb begin
    cnt_next = cnt_q;
    if (mc_issue && !(retire && (cnt_q != '0)))
      cnt_next = cnt_q + CW'(1);
    else if (!mc_issue && retire && (cnt_q != '0))
      cnt_next = cnt_q - CW'(1);
  end

  always_comb begin
    starve_next = starve_q;
    if (fifo_empty || pop)
      starve_next = '0;
    else if (starve_q != SW'(STARVE_LIMIT))
      starve_next = starve_q + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= 32'd0;
      cnt_q        <= '0;
      starve_q     <= '0;
      pipe_stall_q <= 1'b0;
    end else begin
      pending_q    <= pending_next;
      cnt_q        <= cnt_next;
      starve_q     <= starve_next;
      pipe_stall_q <= (starve_next >= SW'(STARVE_LIMIT));
    end
  end

  assign pipe_stall = pipe_stall_q;
  assign pending    = pending_q;
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: directed scenarios plus random traffic against a queue-based model.
module tb_regfile_write_scheduler;
  localparam int FIFO_DEPTH      = 2;
  localparam int MAX_OUTSTANDING = 4;
  localparam int STARVE_LIMIT    = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_wr_en, dec_valid, dec_is_mc, mc_valid;
  logic [4:0]  pipe_rd, dec_rs1, dec_rs2, dec_rd, mc_rd;
  logic [31:0] pipe_wr_data, mc_data;
  logic        mc_ready, wr_en, sb_stall, pipe_stall;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data, pending;

  always #5 clk = ~clk;

  regfile_write_scheduler #(
    .FIFO_DEPTH      (FIFO_DEPTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .STARVE_LIMIT    (STARVE_LIMIT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pipe_wr_en   (pipe_wr_en),
    .pipe_rd      (pipe_rd),
    .pipe_wr_data (pipe_wr_data),
    .dec_valid    (dec_valid),
    .dec_is_mc    (dec_is_mc),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_rd       (dec_rd),
    .mc_valid     (mc_valid),
    .mc_ready     (mc_ready),
    .mc_rd        (mc_rd),
    .mc_data      (mc_data),
    .wr_en        (wr_en),
    .wr_rd        (wr_rd),
    .wr_data      (wr_data),
    .sb_stall     (sb_stall),
    .pipe_stall   (pipe_stall),
    .pending      (pending)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: FIFO contents, pending set, in-flight count, starvation age.
  logic [4:0]  q_rd[$];
  logic [31:0] q_dat[$];
  bit          pend[32];
  int          cnt, starve;
  bit          pstall;
  bit          m_issue, m_acc;
  logic [4:0]  inflight[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_pipe(input logic en, input logic [4:0] rd, input logic [31:0] d);
    pipe_wr_en = en; pipe_rd = rd; pipe_wr_data = d;
  endtask

  task automatic set_dec(input logic v, input logic mc, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd);
    dec_valid = v; dec_is_mc = mc; dec_rs1 = r1; dec_rs2 = r2; dec_rd = rd;
  endtask

  task automatic set_mc(input logic v, input logic [4:0] rd, input logic [31:0] d);
    mc_valid = v; mc_rd = rd; mc_data = d;
  endtask

  task automatic idle_inputs();
    set_pipe(1'b0, 5'd0, 32'd0);
    set_dec(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    set_mc(1'b0, 5'd0, 32'd0);
  endtask

  task automatic reset_dut();
    idle_inputs();
    set_pipe(1'b1, 5'd5, 32'h1111_2222);
    rst_n = 1'b0;
    q_rd.delete(); q_dat.delete(); inflight.delete();
    foreach (pend[i]) pend[i] = 1'b0;
    cnt = 0; starve = 0; pstall = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_mc_ready", 32'(mc_ready), 32'd0);
      check("rst_sb_stall", 32'(sb_stall), 32'd0);
      check("rst_pipe_stall", 32'(pipe_stall), 32'd0);
      check("rst_pending", pending, 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_inputs();
  endtask

  function automatic bit hz(input logic [4:0] r, input bit ret, input logic [4:0] rrd);
    return (r != 5'd0) && pend[r] && !(ret && rrd == r);
  endfunction

  // One clock: compare DUT against the model for the current inputs, then advance the model.
  task automatic step();
    bit busy, pop, byp, ret, ready, e_sb, e_we, push;
    logic [4:0]  rrd, e_rd;
    logic [31:0] e_dat, pvec;
    int qn;
    @(negedge clk);
    qn    = q_rd.size();
    busy  = pipe_wr_en && (pipe_rd != 5'd0);
    pop   = !busy && qn > 0;
    ready = qn < FIFO_DEPTH;
    byp   = 1'b0;
`ifdef REGFILE_SCHED_BYPASS_EN
    byp   = !busy && qn == 0 && mc_valid;
`endif
    ret = pop || byp;
    rrd = mc_rd;
    if (pop) rrd = q_rd[0];
    e_we = 1'b0; e_rd = 5'd0; e_dat = 32'd0;
    if (busy) begin
      e_we = 1'b1; e_rd = pipe_rd; e_dat = pipe_wr_data;
    end else if (pop) begin
      if (q_rd[0] != 5'd0) begin
        e_we = 1'b1; e_rd = q_rd[0]; e_dat = q_dat[0];
      end
    end else if (byp && mc_rd != 5'd0) begin
      e_we = 1'b1; e_rd = mc_rd; e_dat = mc_data;
    end
    e_sb = dec_valid && (hz(dec_rs1, ret, rrd) || hz(dec_rs2, ret, rrd) || hz(dec_rd, ret, rrd) ||
                         (dec_is_mc && cnt == MAX_OUTSTANDING && !ret));
    m_issue = dec_valid && dec_is_mc && !e_sb && !pstall;
    m_acc   = mc_valid && ready;
    push    = m_acc && !byp;
    pvec = 32'd0;
    for (int i = 1; i < 32; i++) pvec[i] = pend[i];

    check("wr_en", 32'(wr_en), 32'(e_we));
    check("wr_rd", 32'(wr_rd), 32'(e_rd));
    check("wr_data", wr_data, e_dat);
    check("mc_ready", 32'(mc_ready), 32'(ready));
    check("sb_stall", 32'(sb_stall), 32'(e_sb));
    check("pipe_stall", 32'(pipe_stall), 32'(pstall));
    check("pending", pending, pvec);

    if (pop) begin
      void'(q_rd.pop_front());
      void'(q_dat.pop_front());
    end
    if (push) begin
      q_rd.push_back(mc_rd);
      q_dat.push_back(mc_data);
    end
    if (ret && rrd != 5'd0) pend[rrd] = 1'b0;
    if (m_issue && dec_rd != 5'd0) pend[dec_rd] = 1'b1;
    cnt = cnt + (m_issue ? 1 : 0) - ((ret && cnt > 0) ? 1 : 0);
    if (qn == 0 || pop) starve = 0;
    else if (starve < STARVE_LIMIT) starve++;
    pstall = (starve >= STARVE_LIMIT);
    @(posedge clk); #1;
  endtask

  initial begin
    int idx;
    idle_inputs();

    // 1: pipeline write passes straight through
    reset_dut();
    set_pipe(1'b1, 5'd5, 32'hA5A5_A5A5);
    #1;
    check("t1_wr_en", 32'(wr_en), 32'd1);
    check("t1_wr_rd", 32'(wr_rd), 32'd5);
    check("t1_wr_data", wr_data, 32'hA5A5_A5A5);
    check("t1_mc_ready", 32'(mc_ready), 32'd1);
    step();

    // 2: RAW hazard on x7 held until its result pops
    reset_dut();
    set_dec(1'b1, 1'b1, 5'd0, 5'd0, 5'd7);
    step();
    set_dec(1'b1, 1'b0, 5'd7, 5'd0, 5'd0);
    #1; check("t2_haz", 32'(sb_stall), 32'd1);
    step(); step();
    set_pipe(1'b1, 5'd2, 32'h0000_0022);
    set_mc(1'b1, 5'd7, 32'h0000_1234);
    #1; check("t2_haz_push", 32'(sb_stall), 32'd1);
    step();
    set_pipe(1'b0, 5'd0, 32'd0);
    set_mc(1'b0, 5'd0, 32'd0);
    #1;
    check("t2_pop_nostall", 32'(sb_stall), 32'd0);
    check("t2_pop_rd", 32'(wr_rd), 32'd7);
    check("t2_pop_data", wr_data, 32'h0000_1234);
    step();
    check("t2_pend7", 32'(pending[7]), 32'd0);

    // 3: outstanding limit, and rd=0 ops still count
    reset_dut();
    for (int i = 1; i <= 4; i++) begin
      set_dec(1'b1, 1'b1, 5'd0, 5'd0, 5'(i));
      step();
    end
    set_dec(1'b1, 1'b1, 5'd0, 5'd0, 5'd5);
    #1; check("t3_limit", 32'(sb_stall), 32'd1);
    step(); step();
    set_pipe(1'b1, 5'd6, 32'h66);
    set_mc(1'b1, 5'd1, 32'h0000_0101);
    #1; check("t3_limit_push", 32'(sb_stall), 32'd1);
    step();
    set_pipe(1'b0, 5'd0, 32'd0);
    set_mc(1'b0, 5'd0, 32'd0);
    #1; check("t3_pop_release", 32'(sb_stall), 32'd0);
    step();
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      set_dec(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
      step();
    end
    set_dec(1'b1, 1'b1, 5'd0, 5'd0, 5'd6);
    #1;
    check("t3_rd0_limit", 32'(sb_stall), 32'd1);
    check("t3_rd0_pending", pending, 32'd0);
    step();

    // 4: starved head forces a pipe_stall cycle
    reset_dut();
    set_pipe(1'b1, 5'd3, 32'h33);
    set_mc(1'b1, 5'd9, 32'h0000_0909);
    step();
    set_mc(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      set_pipe(1'b1, 5'd3, 32'(i));
      #1; check("t4_no_stall", 32'(pipe_stall), 32'd0);
      step();
    end
    set_pipe(1'b0, 5'd0, 32'd0);
    #1;
    check("t4_stall", 32'(pipe_stall), 32'd1);
    check("t4_pop_rd", 32'(wr_rd), 32'd9);
    step();
    check("t4_stall_clear", 32'(pipe_stall), 32'd0);

    // 5: full FIFO backpressure, ordering through push+pop, mid-stream reset
    reset_dut();
    set_pipe(1'b1, 5'd2, 32'h22);
    set_mc(1'b1, 5'd10, 32'h0A); step();
    set_mc(1'b1, 5'd11, 32'h0B); step();
    set_mc(1'b1, 5'd12, 32'h0C);
    #1; check("t5_full", 32'(mc_ready), 32'd0);
    step();
    set_pipe(1'b0, 5'd0, 32'd0);
    #1;
    check("t5_full_pop", 32'(mc_ready), 32'd0);
    check("t5_first", 32'(wr_rd), 32'd10);
    step();
    #1;
    check("t5_pushpop_rdy", 32'(mc_ready), 32'd1);
    check("t5_second", 32'(wr_rd), 32'd11);
    step();
    set_mc(1'b0, 5'd0, 32'd0);
    set_pipe(1'b1, 5'd2, 32'h22);
    #1; check("t5_count1", 32'(mc_ready), 32'd1);
    step();
    set_pipe(1'b0, 5'd0, 32'd0);
    #1; check("t5_third", 32'(wr_rd), 32'd12);
    step();
    set_dec(1'b1, 1'b1, 5'd0, 5'd0, 5'd13);
    set_pipe(1'b1, 5'd2, 32'h22);
    set_mc(1'b1, 5'd14, 32'h0E);
    step();
    check("t5_pend_before", 32'(pending[13]), 32'd1);
    reset_dut();
    #1; check("t5_empty_after", 32'(wr_en), 32'd0);
    step();

    // 6: mc result into an empty FIFO with a free port
    reset_dut();
    set_mc(1'b1, 5'd3, 32'h0000_DEAD);
`ifdef REGFILE_SCHED_BYPASS_EN
    #1;
    check("t6_byp_en", 32'(wr_en), 32'd1);
    check("t6_byp_rd", 32'(wr_rd), 32'd3);
    check("t6_byp_data", wr_data, 32'h0000_DEAD);
    step();
    set_mc(1'b0, 5'd0, 32'd0);
    #1; check("t6_no_occupancy", 32'(wr_en), 32'd0);
    step();
`else
    #1; check("t6_buffered", 32'(wr_en), 32'd0);
    step();
    set_mc(1'b0, 5'd0, 32'd0);
    #1;
    check("t6_late_en", 32'(wr_en), 32'd1);
    check("t6_late_rd", 32'(wr_rd), 32'd3);
    check("t6_late_data", wr_data, 32'h0000_DEAD);
    step();
`endif

    // Random traffic with a mc unit returning issued results out of order
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      set_pipe(($urandom_range(3) != 0) && !pstall, 5'($urandom_range(7)), $urandom);
      set_dec(1'($urandom_range(1)), 1'($urandom_range(1)), 5'($urandom_range(7)),
              5'($urandom_range(7)), 5'($urandom_range(7)));
      set_mc(1'b0, 5'd0, $urandom);
      idx = 0;
      if (inflight.size() > 0 && $urandom_range(2) == 0) begin
        idx = $urandom_range(inflight.size() - 1);
        mc_valid = 1'b1;
        mc_rd = inflight[idx];
      end
      step();
      if (m_acc) inflight.delete(idx);
      if (m_issue) inflight.push_back(dec_rd);
      if (c % 1000 == 999) reset_dut();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
